// File: rtl/mem_stage_controller.sv
// MEM pipeline stage: drives a request/ack data-memory port, stalls upstream while an access is
// outstanding, resolves jumps/branches and registers the MEM/WB outputs. Optional macro: MEM_TIMEOUT_EN.
module mem_stage_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_Valid,
    input  logic        in_Zero,
    input  logic [31:0] in_ALUResult,
    input  logic [31:0] in_ReadData2,
    input  logic [31:0] in_JumpAddress,
    input  logic [31:0] in_BranchAddress,
    input  logic [31:0] in_PC_4,
    input  logic [4:0]  in_WriteRegister,
    input  logic        in_CtrlRegWrite,
    input  logic        in_CtrlJump,
    input  logic        in_CtrlMemRead,
    input  logic        in_CtrlMemWrite,
    input  logic        in_CtrlALUOrMem,
    input  logic        in_CtrlBranchEquals,
    input  logic        in_CtrlBranchNotEquals,
    input  logic        in_CtrlALUMemOrPC,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_target,
    output logic        out_Valid,
    output logic [31:0] out_WriteData,
    output logic [4:0]  out_WriteRegister,
    output logic        out_CtrlRegWrite
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        mem_error
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        access_req;
    logic        ack_done;
    logic        timeout_hit;
    logic        update_wb;
    logic [31:0] rdata_reg;
    logic [31:0] mem_value;
    logic [31:0] wb_value;

    assign access_req = in_Valid & (in_CtrlMemRead | in_CtrlMemWrite);
    assign ack_done   = (state_reg == BUSY) & mem_ack;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] busy_cnt_reg;

    // Counter holds 14 during the 15th BUSY cycle; the closing edge of that cycle is the timeout.
    assign timeout_hit = (state_reg == BUSY) & ~mem_ack & (busy_cnt_reg == 4'd14);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt_reg <= 4'd0;
            mem_error    <= 1'b0;
        end else begin
            if (state_reg == IDLE)
                busy_cnt_reg <= 4'd0;
            else if (!mem_ack)
                busy_cnt_reg <= busy_cnt_reg + 4'd1;
            if (timeout_hit)
                mem_error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access_req) begin
                    state_next = BUSY;
                    stall      = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack || timeout_hit)
                    state_next = IDLE;
                else
                    stall = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // On the completing edge the fresh read data bypasses the capture register.
    assign mem_value = ack_done ? mem_rdata : rdata_reg;

    always_comb begin
        wb_value = in_ALUResult;
        if (in_CtrlALUMemOrPC)
            wb_value = in_PC_4;
        else if (in_CtrlALUOrMem)
            wb_value = mem_value;
    end

    assign update_wb       = in_Valid & ~stall;
    assign redirect        = update_wb & (in_CtrlJump | (in_CtrlBranchEquals & in_Zero)
                                          | (in_CtrlBranchNotEquals & ~in_Zero));
    assign redirect_target = in_CtrlJump ? in_JumpAddress : in_BranchAddress;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && access_req) begin
                mem_req   <= 1'b1;
                mem_we    <= in_CtrlMemWrite;
                mem_addr  <= in_ALUResult;
                mem_wdata <= in_ReadData2;
            end else if (state_reg == BUSY && (mem_ack || timeout_hit)) begin
                mem_req <= 1'b0;
                if (mem_ack)
                    rdata_reg <= mem_rdata;
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            out_Valid         <= 1'b0;
            out_WriteData     <= 32'd0;
            out_WriteRegister <= 5'd0;
            out_CtrlRegWrite  <= 1'b0;
        end else if (update_wb) begin
            out_Valid         <= 1'b1;
            out_WriteData     <= wb_value;
            out_WriteRegister <= in_WriteRegister;
            out_CtrlRegWrite  <= in_CtrlRegWrite & (|in_WriteRegister) & ~timeout_hit;
        end else begin
            out_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_controller.sv
// Self-checking bench for mem_stage_controller: directed scenarios plus randomized instructions
// checked against a per-instruction model (stall length, memory port, redirect, write-back).
module tb_mem_stage_controller;

    logic        clk;
    logic        reset;
    logic        in_Valid, in_Zero;
    logic [31:0] in_ALUResult, in_ReadData2, in_JumpAddress, in_BranchAddress, in_PC_4;
    logic [4:0]  in_WriteRegister;
    logic        in_CtrlRegWrite, in_CtrlJump, in_CtrlMemRead, in_CtrlMemWrite;
    logic        in_CtrlALUOrMem, in_CtrlBranchEquals, in_CtrlBranchNotEquals, in_CtrlALUMemOrPC;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, redirect;
    logic [31:0] redirect_target;
    logic        out_Valid, out_CtrlRegWrite;
    logic [31:0] out_WriteData;
    logic [4:0]  out_WriteRegister;
`ifdef MEM_TIMEOUT_EN
    logic        mem_error;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata = 32'd0;

    typedef struct {
        logic        valid, z, rw, j, mr, mw, aom, beq, bne, apc;
        logic [31:0] alu, rd2, ja, ba, pc4;
        logic [4:0]  wr;
    } instr_t;

    mem_stage_controller dut (
        .clk(clk), .reset(reset),
        .in_Valid(in_Valid), .in_Zero(in_Zero), .in_ALUResult(in_ALUResult),
        .in_ReadData2(in_ReadData2), .in_JumpAddress(in_JumpAddress),
        .in_BranchAddress(in_BranchAddress), .in_PC_4(in_PC_4),
        .in_WriteRegister(in_WriteRegister), .in_CtrlRegWrite(in_CtrlRegWrite),
        .in_CtrlJump(in_CtrlJump), .in_CtrlMemRead(in_CtrlMemRead),
        .in_CtrlMemWrite(in_CtrlMemWrite), .in_CtrlALUOrMem(in_CtrlALUOrMem),
        .in_CtrlBranchEquals(in_CtrlBranchEquals), .in_CtrlBranchNotEquals(in_CtrlBranchNotEquals),
        .in_CtrlALUMemOrPC(in_CtrlALUMemOrPC),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .out_Valid(out_Valid), .out_WriteData(out_WriteData),
        .out_WriteRegister(out_WriteRegister), .out_CtrlRegWrite(out_CtrlRegWrite)
`ifdef MEM_TIMEOUT_EN
        , .mem_error(mem_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t blank();
        instr_t t;
        t.valid = 1'b1; t.z = 1'b0; t.rw = 1'b0; t.j = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
        t.aom = 1'b0; t.beq = 1'b0; t.bne = 1'b0; t.apc = 1'b0;
        t.alu = $urandom; t.rd2 = $urandom; t.ja = $urandom; t.ba = $urandom; t.pc4 = $urandom;
        t.wr = 5'($urandom_range(1, 31));
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t = blank();
        t.valid = ($urandom_range(0, 7) != 0);
        t.z   = 1'($urandom); t.rw  = 1'($urandom);
        t.j   = ($urandom_range(0, 5) == 0);
        t.mr  = ($urandom_range(0, 2) == 0);
        t.mw  = ($urandom_range(0, 3) == 0);
        t.aom = 1'($urandom); t.apc = ($urandom_range(0, 4) == 0);
        t.beq = ($urandom_range(0, 4) == 0); t.bne = ($urandom_range(0, 4) == 0);
        t.wr  = 5'($urandom_range(0, 31));
        return t;
    endfunction

    task automatic apply(input instr_t t);
        in_Valid = t.valid; in_Zero = t.z; in_ALUResult = t.alu; in_ReadData2 = t.rd2;
        in_JumpAddress = t.ja; in_BranchAddress = t.ba; in_PC_4 = t.pc4; in_WriteRegister = t.wr;
        in_CtrlRegWrite = t.rw; in_CtrlJump = t.j; in_CtrlMemRead = t.mr; in_CtrlMemWrite = t.mw;
        in_CtrlALUOrMem = t.aom; in_CtrlBranchEquals = t.beq; in_CtrlBranchNotEquals = t.bne;
        in_CtrlALUMemOrPC = t.apc;
    endtask

    // Runs one instruction to retirement; d = BUSY cycles without ack before the ack cycle.
    // Called just after a falling (active) edge; returns just after the retiring edge.
    task automatic run_instr(input string name, input instr_t t, input int d, input logic [31:0] rdata);
        bit          access = t.valid && (t.mr || t.mw);
        int          n_stall = access ? 1 + d : 0;
        bit          taken = t.j || (t.beq && t.z) || (t.bne && !t.z);
        logic [31:0] exp_target = t.j ? t.ja : t.ba;
        logic [31:0] exp_wb;
        bit          exp_stall;
        apply(t);
        for (int c = 0; c <= n_stall; c++) begin
            // In IDLE a random ack must be ignored; otherwise ack only in the final cycle.
            mem_ack   = access ? ((c == 0) ? 1'($urandom) : (c == n_stall)) : 1'($urandom);
            mem_rdata = (access && c == n_stall) ? rdata : $urandom;
            @(posedge clk);
            exp_stall = (c < n_stall);
            checks++;
            if (stall !== exp_stall) begin
                errors++; $display("FAIL %s stall c=%0d: got %b want %b", name, c, stall, exp_stall);
            end
            checks++;
            if (redirect !== (t.valid && !exp_stall && taken)) begin
                errors++; $display("FAIL %s redirect c=%0d: got %b want %b", name, c, redirect,
                                   t.valid && !exp_stall && taken);
            end
            if (t.valid && taken && !exp_stall) begin
                checks++;
                if (redirect_target !== exp_target) begin
                    errors++; $display("FAIL %s target: got %h want %h", name, redirect_target, exp_target);
                end
            end
            if (access && c >= 1) begin
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, t.mw, t.alu, t.rd2}) begin
                    errors++;
                    $display("FAIL %s memport c=%0d: got req=%b we=%b a=%h wd=%h want req=1 we=%b a=%h wd=%h",
                             name, c, mem_req, mem_we, mem_addr, mem_wdata, t.mw, t.alu, t.rd2);
                end
            end
            @(negedge clk); #1;
            if (exp_stall) begin
                checks++;
                if (out_Valid !== 1'b0) begin
                    errors++; $display("FAIL %s out_Valid during stall: got %b want 0", name, out_Valid);
                end
            end
        end
        mem_ack = 1'b0;
        if (access) last_rdata = rdata;
        exp_wb = t.apc ? t.pc4 : (t.aom ? last_rdata : t.alu);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL %s mem_req after retire: got %b want 0", name, mem_req);
        end
        checks++;
        if (out_Valid !== t.valid) begin
            errors++; $display("FAIL %s out_Valid: got %b want %b", name, out_Valid, t.valid);
        end
        if (t.valid) begin
            checks++;
            if ({out_WriteData, out_WriteRegister, out_CtrlRegWrite} !== {exp_wb, t.wr, t.rw && (t.wr != 0)}) begin
                errors++;
                $display("FAIL %s writeback: got wd=%h wr=%0d rw=%b want wd=%h wr=%0d rw=%b", name,
                         out_WriteData, out_WriteRegister, out_CtrlRegWrite, exp_wb, t.wr, t.rw && (t.wr != 0));
            end
        end
        $display("txn %s: valid=%b access=%b ack_delay=%0d wb=%h", name, t.valid, access, d, exp_wb);
    endtask

    task automatic test_reset();
        instr_t t = blank();
        t.valid = 1'b0;
        apply(t);
        mem_ack = 1'b0; mem_rdata = 32'd0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, out_Valid, out_WriteData, out_WriteRegister, out_CtrlRegWrite} !== '0) begin
            errors++;
            $display("FAIL reset_state: got req=%b we=%b a=%h wd=%h ov=%b owd=%h owr=%0d orw=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, out_Valid, out_WriteData, out_WriteRegister, out_CtrlRegWrite);
        end
        reset = 1'b1;
        $display("txn reset: released");
    endtask

    task automatic test_directed();
        instr_t t;
        t = blank(); t.mr = 1'b1; t.aom = 1'b1; t.rw = 1'b1; t.alu = 32'h10; t.wr = 5'd8;
        run_instr("load", t, 3, 32'hDEADBEEF);
        t = blank(); t.mw = 1'b1; t.rd2 = 32'h55;
        run_instr("store", t, 1, 32'h0);
        t = blank(); t.mr = 1'b1; t.mw = 1'b1; t.aom = 1'b1; t.rw = 1'b1;
        run_instr("rw_both", t, 0, 32'h1234_5678);
        t = blank(); t.bne = 1'b1; t.z = 1'b0; t.ba = 32'h40;
        run_instr("bne", t, 0, 32'h0);
        t = blank(); t.j = 1'b1; t.beq = 1'b1; t.z = 1'b1; t.ja = 32'h80;
        run_instr("jump_beq", t, 0, 32'h0);
        t = blank(); t.beq = 1'b1; t.z = 1'b0;
        run_instr("beq_not_taken", t, 0, 32'h0);
        t = blank(); t.rw = 1'b1; t.wr = 5'd0;
        run_instr("rtype_r0", t, 0, 32'h0);
        t = blank(); t.apc = 1'b1; t.rw = 1'b1; t.pc4 = 32'h24; t.wr = 5'd31;
        run_instr("jal", t, 0, 32'h0);
        t = blank(); t.aom = 1'b1; t.rw = 1'b1;
        run_instr("captured_rdata", t, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        instr_t t;
        for (int i = 0; i < 4; i++) begin
            t = blank(); t.mr = 1'b1; t.aom = 1'b1; t.rw = 1'b1;
            run_instr("b2b_load", t, 0, $urandom);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++)
            run_instr("rand", rand_instr(), $urandom_range(0, 5), $urandom);
    endtask

    task automatic test_reset_busy();
        instr_t t = blank();
        t.mr = 1'b1; t.aom = 1'b1; t.rw = 1'b1;
        apply(t);
        mem_ack = 1'b0;
        @(negedge clk); #1;
        @(posedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_busy pre: mem_req got %b want 1", mem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, out_Valid} !== 2'b00) begin
            errors++; $display("FAIL rst_busy immediate: got req=%b ov=%b want 0 0", mem_req, out_Valid);
        end
        in_Valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk); #1;
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, out_Valid} !== 2'b00) begin
            errors++; $display("FAIL rst_busy late_ack: got req=%b ov=%b want 0 0", mem_req, out_Valid);
        end
        last_rdata = 32'd0;
        $display("txn reset_in_busy: late ack discarded");
        t = blank(); t.mr = 1'b1; t.aom = 1'b1; t.rw = 1'b1;
        run_instr("after_reset_load", t, 2, 32'hCAFE_F00D);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        instr_t t = blank();
        t.mr = 1'b1; t.rw = 1'b1;
        apply(t);
        mem_ack = 1'b0;
        checks++;
        if (mem_error !== 1'b0) begin
            errors++; $display("FAIL timeout pre: mem_error got %b want 0", mem_error);
        end
        for (int c = 0; c <= 15; c++) begin
            @(posedge clk);
            checks++;
            if (stall !== (c < 15)) begin
                errors++; $display("FAIL timeout stall c=%0d: got %b want %b", c, stall, c < 15);
            end
            @(negedge clk); #1;
        end
        checks++;
        if ({mem_error, out_Valid, out_CtrlRegWrite, mem_req} !== 4'b1100) begin
            errors++; $display("FAIL timeout result: got err=%b ov=%b rw=%b req=%b want 1 1 0 0",
                               mem_error, out_Valid, out_CtrlRegWrite, mem_req);
        end
        $display("txn timeout: mem_error=%b", mem_error);
    endtask
`endif

    initial begin
        reset = 1'b1;
        @(negedge clk); #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_busy();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_controller.md
MEM_STAGE_CONTROLLER -- requirements
Module: mem_stage_controller

Interface
REQ-001 The block SHALL have ports clk (in, 1, single clock; all state updates on the falling edge) and reset (in, 1, asynchronous, active-low).
REQ-002 The block SHALL have EX/MEM-side inputs:
- in_Valid (1)
- in_Zero (1)
- in_ALUResult (32, memory address / ALU value)
- in_ReadData2 (32, store data)
- in_JumpAddress (32)
- in_BranchAddress (32)
- in_PC_4 (32)
- in_WriteRegister (5)
- in_CtrlRegWrite, in_CtrlJump, in_CtrlMemRead, in_CtrlMemWrite, in_CtrlALUOrMem, in_CtrlBranchEquals, in_CtrlBranchNotEquals, in_CtrlALUMemOrPC (1 each)
REQ-003 The block SHALL have memory-port signals:
- mem_req (out, 1)
- mem_we (out, 1)
- mem_addr (out, 32)
- mem_wdata (out, 32)
- mem_ack (in, 1)
- mem_rdata (in, 32)
REQ-004 The block SHALL have pipeline-control outputs:
- stall (1, freeze upstream stages)
- redirect (1, PC takes redirect_target)
- redirect_target (32)
REQ-005 The block SHALL have MEM/WB outputs:
- out_Valid (1)
- out_WriteData (32)
- out_WriteRegister (5)
- out_CtrlRegWrite (1)

Function
REQ-006 The block SHALL be a two-state FSM: IDLE and BUSY.
REQ-007 An access SHALL be requested when in_Valid=1 and (in_CtrlMemRead|in_CtrlMemWrite)=1; if both are set, the write wins (mem_we=1).
REQ-008 In IDLE with an access requested, the block SHALL go to BUSY at the next edge, registering mem_req=1, mem_we, mem_addr=in_ALUResult and mem_wdata=in_ReadData2.
REQ-009 In BUSY, mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until the edge at which mem_ack=1 is sampled.
- At that edge: mem_req goes to 0, mem_rdata is captured and the FSM returns to IDLE.
- Minimum access latency is therefore 2 cycles.
REQ-010 stall SHALL be combinational and equal 1 when (IDLE and an access is requested) or (BUSY and mem_ack=0); otherwise 0.
REQ-011 mem_ack sampled while in IDLE SHALL be ignored.
REQ-012 The write-back value SHALL be selected as follows:
- in_CtrlALUMemOrPC=1: in_PC_4
- else in_CtrlALUOrMem=1: the captured mem_rdata (mem_rdata itself on the completing edge)
- else: in_ALUResult
REQ-013 MEM/WB outputs SHALL update at an edge only when in_Valid=1 and stall=0; at any other edge out_Valid SHALL be 0 and the other MEM/WB outputs SHALL hold.
REQ-014 out_CtrlRegWrite SHALL equal in_CtrlRegWrite, forced to 0 when in_WriteRegister=0.
REQ-015 redirect SHALL be combinational and equal in_Valid & stall=0 & (in_CtrlJump | (in_CtrlBranchEquals & in_Zero) | (in_CtrlBranchNotEquals & ~in_Zero)).
REQ-016 redirect_target SHALL be in_JumpAddress when in_CtrlJump=1 (jump has priority), otherwise in_BranchAddress.
REQ-017 Back-to-back accesses SHALL pass through IDLE for at least one edge between them; no request overlap is permitted.

Reset
REQ-018 Asserting reset SHALL, at any time including mid-access, immediately force:
- the FSM to IDLE
- mem_req, mem_we, mem_addr, mem_wdata to 0
- out_Valid, out_WriteData, out_WriteRegister, out_CtrlRegWrite to 0
REQ-019 After reset is released, the first request SHALL take the normal REQ-008 path; an ack that was outstanding at reset SHALL be discarded.

Configuration
REQ-020 With MEM_TIMEOUT_EN defined:
- A 4-bit counter SHALL count BUSY cycles.
- On reaching 15 without mem_ack, the block SHALL return to IDLE, drop mem_req, and emit the instruction with out_Valid=1 and out_CtrlRegWrite=0.
- The block SHALL set a sticky output mem_error (1 bit, cleared only by reset).
REQ-021 Without MEM_TIMEOUT_EN, BUSY SHALL wait indefinitely for mem_ack, and neither the mem_error port nor the counter SHALL exist.

Verification
REQ-022 Load with ALUResult=0x10, ALUOrMem=1, WriteRegister=8, ack after 3 cycles, rdata=0xDEADBEEF -> stall high 4 cycles, mem_addr=0x10, then out_WriteData=0xDEADBEEF, out_WriteRegister=8, out_Valid=1.
REQ-023 Store with MemWrite=1, ReadData2=0x55 -> mem_we=1, mem_wdata=0x55 until ack; ack in the same cycle as BUSY entry+1 -> stall exactly 2 cycles.
REQ-024 BNE with Zero=0, BranchAddress=0x40 -> redirect=1, target=0x40; Jump=1 together with BEQ/Zero=1 and JumpAddress=0x80 -> target=0x80.
REQ-025 R-type with RegWrite=1, WriteRegister=0 -> out_CtrlRegWrite=0; JAL with ALUMemOrPC=1, PC_4=0x24 -> out_WriteData=0x24.
REQ-026 Reset asserted while in BUSY -> mem_req=0 and out_Valid=0 immediately; a late ack after release -> no output produced.
REQ-027 With MEM_TIMEOUT_EN defined and no ack -> after 15 BUSY cycles mem_error=1, out_Valid=1 and out_CtrlRegWrite=0.
